// File: rtl/verdict_ser_pkg.sv
// Shared types and constants for the RTLola verdict serializer.
// VERDICT_SER_CRC_EN adds the CRC state used to append a CRC-8 byte to each frame.
package verdict_ser_pkg;

  localparam int TS_W     = 32;
  localparam int TS_BYTES = TS_W / 8;
  localparam int IDX_W    = (TS_BYTES > 8) ? $clog2(TS_BYTES) : 3;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [1:0]      mask;
    logic [63:0]     v0;
    logic [63:0]     v1;
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_MASK = 3'd2,
    ST_TS   = 3'd3,
    ST_V0   = 3'd4,
    ST_V1   = 3'd5
`ifdef VERDICT_SER_CRC_EN
    , ST_CRC = 3'd6
`endif
  } state_t;

  // CRC-8, MSB first, no reflection: fold one byte into the running remainder.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is taken only when a pop happens on the same edge.
module verdict_fifo
  import verdict_ser_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  rec_t                   wr_data_i,
  input  logic                   pop_i,
  output rec_t                   rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  rec_t          mem_q [DEPTH];
  logic          push_ok_s;
  logic          pop_ok_s;

  // Accept/consume qualification and status flags.
  always_comb begin
    full_o    = (count_q == (AW+1)'(DEPTH));
    empty_o   = (count_q == (AW+1)'(0));
    push_ok_s = push_i & (~full_o | pop_i);
    pop_ok_s  = pop_i & ~empty_o;
    rd_data_o = mem_q[rd_ptr_q];
    level_o   = count_q;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/verdict_serializer.sv
// Captures active RTLola monitor outputs with a timestamp and streams them as byte frames.
// Define VERDICT_SER_CRC_EN to append a CRC-8 over mask, timestamp and value bytes.
module verdict_serializer
  import verdict_ser_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [63:0]     output_0,
  input  logic                   output_0_aktv,
  input  logic signed [63:0]     output_1,
  input  logic                   output_1_aktv,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  logic [TS_W-1:0]          ts_q;
  logic [TS_W-1:0]          ts_d;
  logic [15:0]              drop_q;
  logic [15:0]              drop_d;
  state_t                   state_q;
  logic [IDX_W-1:0]         idx_q;
  rec_t                     hold_q;
  logic [7:0]               tx_data_q;
  logic                     tx_valid_q;

  logic                     cap_s;
  rec_t                     cap_rec_s;
  rec_t                     fifo_rd_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [$clog2(DEPTH):0]   fifo_level_s;
  logic                     pop_s;
  logic                     drop_s;
  logic                     hs_s;
  logic [IDX_W-1:0]         idx_inc_s;
  logic                     ts_last_s;
  logic                     val_last_s;
  logic [TS_W-1:0]          ts_shift_s;
  logic [63:0]              v0_shift_s;
  logic [63:0]              v1_shift_s;

  // Capture, pop and handshake qualifiers; shifted copies give the next MSB-first byte.
  always_comb begin
    cap_s          = en & (output_0_aktv | output_1_aktv);
    cap_rec_s.ts   = ts_q;
    cap_rec_s.mask = {output_1_aktv, output_0_aktv};
    cap_rec_s.v0   = output_0;
    cap_rec_s.v1   = output_1;
    pop_s          = (state_q == ST_IDLE) & ~fifo_empty_s;
    drop_s         = cap_s & fifo_full_s & ~pop_s;
    hs_s           = tx_valid_q & tx_ready;
    idx_inc_s      = idx_q + IDX_W'(1);
    ts_last_s      = (idx_q == IDX_W'(TS_BYTES - 1));
    val_last_s     = (idx_q == IDX_W'(7));
    ts_shift_s     = hold_q.ts << {idx_inc_s, 3'b000};
    v0_shift_s     = hold_q.v0 << {idx_inc_s, 3'b000};
    v1_shift_s     = hold_q.v1 << {idx_inc_s, 3'b000};
  end

  // Next-state for the timestamp and the saturating drop counter.
  always_comb begin
    if (en) begin
      ts_d = ts_q + TS_W'(1);
    end else begin
      ts_d = ts_q;
    end
    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Timestamp and drop counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q   <= TS_W'(0);
      drop_q <= 16'h0000;
    end else begin
      ts_q   <= ts_d;
      drop_q <= drop_d;
    end
  end

  verdict_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push_i   (cap_s),
    .wr_data_i(cap_rec_s),
    .pop_i    (pop_s),
    .rd_data_o(fifo_rd_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s),
    .level_o  (fifo_level_s)
  );

`ifdef VERDICT_SER_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_next_s;

  assign crc_next_s = crc8_update(crc_q, tx_data_q);

  // Running CRC: cleared while the header is on the wire, folded on each later accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 8'h00;
    end else if (state_q == ST_HDR) begin
      crc_q <= 8'h00;
    end else if (hs_s && (state_q inside {ST_MASK, ST_TS, ST_V0, ST_V1})) begin
      crc_q <= crc_next_s;
    end
  end
`endif

  // Frame FSM: tx_data is loaded with the following byte on each accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= IDX_W'(0);
      hold_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            hold_q     <= fifo_rd_s;
            state_q    <= ST_HDR;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HDR_BYTE;
          end
        end
        ST_HDR: begin
          if (hs_s) begin
            state_q   <= ST_MASK;
            tx_data_q <= {6'b000000, hold_q.mask};
          end
        end
        ST_MASK: begin
          if (hs_s) begin
            state_q   <= ST_TS;
            idx_q     <= IDX_W'(0);
            tx_data_q <= hold_q.ts[TS_W-1 -: 8];
          end
        end
        ST_TS: begin
          if (hs_s) begin
            if (ts_last_s) begin
              idx_q <= IDX_W'(0);
              if (hold_q.mask[0]) begin
                state_q   <= ST_V0;
                tx_data_q <= hold_q.v0[63:56];
              end else begin
                state_q   <= ST_V1;
                tx_data_q <= hold_q.v1[63:56];
              end
            end else begin
              idx_q     <= idx_inc_s;
              tx_data_q <= ts_shift_s[TS_W-1 -: 8];
            end
          end
        end
        ST_V0: begin
          if (hs_s) begin
            if (!val_last_s) begin
              idx_q     <= idx_inc_s;
              tx_data_q <= v0_shift_s[63:56];
            end else if (hold_q.mask[1]) begin
              state_q   <= ST_V1;
              idx_q     <= IDX_W'(0);
              tx_data_q <= hold_q.v1[63:56];
            end else begin
`ifdef VERDICT_SER_CRC_EN
              state_q    <= ST_CRC;
              tx_data_q  <= crc_next_s;
`else
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
`endif
            end
          end
        end
        ST_V1: begin
          if (hs_s) begin
            if (!val_last_s) begin
              idx_q     <= idx_inc_s;
              tx_data_q <= v1_shift_s[63:56];
            end else begin
`ifdef VERDICT_SER_CRC_EN
              state_q    <= ST_CRC;
              tx_data_q  <= crc_next_s;
`else
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
`endif
            end
          end
        end
`ifdef VERDICT_SER_CRC_EN
        ST_CRC: begin
          if (hs_s) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign drop_cnt   = drop_q;
  assign fifo_level = fifo_level_s;

endmodule

// File: doc/verdict_serializer.md
# verdict_serializer

Downstream consumer of the generated RTLola monitor (`topEntity`). Each cycle in which any monitor output stream is active, the block captures the active values together with a cycle timestamp into a small FIFO. It then serializes each record as a byte-oriented frame over a valid/ready stream for a UART or host-link bridge. The monitor's verdicts leave the chip in order, with a count of any that had to be dropped.

## Interface
- `DEPTH`, 8: FIFO depth in records; power of two, at least 2.
- `TS_W`, 32: timestamp width; fixed multiple of 8.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: global enable, shared with the monitor.
- `output_0` in 64: monitor stream 0 value, signed.
- `output_0_aktv` in 1: stream 0 active this cycle.
- `output_1` in 64: monitor stream 1 value, signed.
- `output_1_aktv` in 1: stream 1 active this cycle.
- `tx_data` out 8: frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte.
- `drop_cnt` out 16: records lost to overflow; saturating.
- `fifo_level` out clog2(DEPTH)+1: records held.

## Operation
- Timestamp counter `ts`, `TS_W` bits:
  - Cleared by reset.
  - Increments on every `clk` edge where `en`=1; wraps modulo 2^TS_W.
  - Holds while `en`=0.
- Capture:
  - Occurs on an edge where `en`=1 and (`output_0_aktv` | `output_1_aktv`).
  - Pushes the record {`ts` pre-increment value, mask = {aktv1, aktv0}, `output_0`, `output_1`}.
  - With `en`=0, nothing is captured.
- Overflow:
  - Applies when the FIFO is full and no pop occurs in the same cycle.
  - The record is discarded and `drop_cnt` increments, saturating at 0xFFFF.
  - A simultaneous pop and push on a full FIFO is accepted; nothing is dropped.
- Frame, bytes in order:
  - 0xA5 header.
  - Mask byte, 0b000000 followed by aktv1 and aktv0.
  - Timestamp, MSB first, TS_W/8 bytes.
  - 8 bytes of `output_0`, MSB first, only if mask[0].
  - 8 bytes of `output_1`, MSB first, only if mask[1].
  - Optional CRC byte; see Configuration.
- FSM states: IDLE, HDR, MASK, TS, V0, V1, CRC.
  - IDLE→HDR when the FIFO is non-empty. The record is popped into the holding register on this transition.
  - Each state advances only on `tx_valid & tx_ready`. Multi-byte states use a byte index counter and exit on the last byte.
  - MASK→TS.
  - TS→V0 if mask[0], else V1 if mask[1].
  - V0→V1 if mask[1], else end of frame.
  - V1→end of frame.
  - End of frame is CRC when enabled, else IDLE.
  - CRC→IDLE.
  - The FSM drains regardless of `en`.

## Timing
- Capture edge N: the record is visible in `fifo_level` after edge N. The pop happens at edge N+1 if the FSM is idle. `tx_valid`=1 with 0xA5 after edge N+1, i.e. 2 cycles of latency.
- `tx_data` is registered. It is stable while `tx_valid`=1 and `tx_ready`=0.
- `tx_valid` stays high for the whole frame, provided `tx_ready` is held high.
- Back-to-back frames: returning to IDLE costs one idle cycle between frames.
- Reset values:
  - `tx_valid`=0, `tx_data`=0x00, `drop_cnt`=0, `fifo_level`=0.
  - `ts`=0; FSM in IDLE.
- Reset mid-frame: the frame is abandoned and the FIFO flushed. Outputs return to reset values asynchronously.

## Configuration
- `VERDICT_SER_CRC_EN`: when defined, a CRC-8 byte is appended to each frame.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Covers all bytes after the header: mask, timestamp and values.
- When not defined, no CRC state and no CRC byte exist. The frame ends after the last value byte.

## Structure
- Package `verdict_ser_pkg` holds:
  - the record struct;
  - the `HDR_BYTE` constant (0xA5);
  - the `CRC_POLY` constant (0x07);
  - the FSM state enum;
  - a CRC-8 byte-update function.
- Sub-module `verdict_fifo`: synchronous FIFO of `DEPTH` records. Provides push/pop, full/empty and level, and supports simultaneous push and pop when full.

## Test plan
- Single capture:
  - Stimulus: at ts=5, aktv=(0,1), `output_0`=0x0123456789ABCDEF; `tx_ready` held 1.
  - Required: bytes A5 01 00 00 00 05 01 23 45 67 89 AB CD EF, plus CRC if enabled. `tx_valid` rises 2 cycles after capture.
- Both active:
  - Stimulus: `output_0`=-1, `output_1`=2.
  - Required: mask byte 03, followed by FF×8 then 00×7 02.
- Backpressure:
  - Stimulus: `tx_ready` toggles 1/0 every cycle.
  - Required: every byte is held while not ready; no byte is duplicated or skipped.
- Overflow:
  - Stimulus: `tx_ready`=0 with 12 consecutive captures, DEPTH=8. This fills the holding register plus the FIFO.
  - Required: `drop_cnt`=3, `fifo_level`=8. After releasing `tx_ready`, 9 frames are emitted in order.
- Enable gating:
  - Stimulus: `en`=0 for 10 cycles with aktv high.
  - Required: no capture and `ts` frozen. A frame already in flight completes.
- Reset mid-frame:
  - Stimulus: `rst` low during the TS bytes.
  - Required: `tx_valid` is 0 immediately. After release, `fifo_level`=0, `drop_cnt`=0, and the next capture has ts=0.
